// File: rtl/parzen_frame_windower.sv
// parzen_frame_windower
//   Streaming frame windower. Tracks the sample position n inside each
//   N = 2**WINDOW_SIZE_POW2 frame, presents |n - N/2| to an external Parzen
//   coefficient block on tri_o, takes the coefficient back on win_i, multiplies
//   it into the sample, then rounds and saturates the result. Output is a
//   valid/ready stream.
//
// Ports
//   clk_i      clock, all logic on the rising edge
//   rst_i      synchronous active-high reset
//   s_valid_i  input sample valid
//   s_ready_o  input ready (combinational, equals the pipe advance)
//   s_data_i   signed input sample
//   s_first_i  forces this sample to position 0 (frame resync)
//   tri_o      |n - N/2| of the sample held in stage 1
//   win_i      unsigned WIN_INT.WIN_FRAC coefficient, combinational from tri_o
//   m_valid_o  output valid
//   m_ready_i  output ready
//   m_data_o   signed, rounded and saturated windowed sample
//   m_last_o   marks the output for position N-1
//   resync_o   one-cycle pulse when s_first_i is accepted with n != 0
module parzen_frame_windower #(
  parameter int WINDOW_SIZE_POW2 = 10,
  parameter int SAMPLE_W         = 16,
  parameter int WIN_INT          = 10,
  parameter int WIN_FRAC         = 16,
  parameter int OUT_W            = 18
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          s_valid_i,
  output logic                          s_ready_o,
  input  logic [SAMPLE_W-1:0]           s_data_i,
  input  logic                          s_first_i,
  output logic [WINDOW_SIZE_POW2-1:0]   tri_o,
  input  logic [WIN_INT+WIN_FRAC-1:0]   win_i,
  output logic                          m_valid_o,
  input  logic                          m_ready_i,
  output logic [OUT_W-1:0]              m_data_o,
  output logic                          m_last_o,
  output logic                          resync_o
);

  localparam int W  = WINDOW_SIZE_POW2;
  localparam int WW = WIN_INT + WIN_FRAC;
  localparam int PW = SAMPLE_W + WW + 1;

  localparam logic [W-1:0] C_LAST = {W{1'b1}};
  localparam logic [W-1:0] C_HALF = {1'b1, {(W-1){1'b0}}};

  localparam logic signed [PW-1:0] C_RND = {{(PW-WIN_FRAC){1'b0}}, 1'b1, {(WIN_FRAC-1){1'b0}}};
  localparam logic signed [PW-1:0] C_MAX = {{(PW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [PW-1:0] C_MIN = {{(PW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic                        w_adv;
  logic                        w_accept;
  logic [W-1:0]                w_pos;
  logic [W-1:0]                w_tri;
  logic signed [PW-1:0]        w_mul_a;
  logic signed [PW-1:0]        w_mul_b;
  logic signed [PW-1:0]        w_prod;
  logic signed [PW-1:0]        w_round;
  logic [OUT_W-1:0]            w_sat;

  logic [W-1:0]                r_n;
  logic                        r_s1_valid;
  logic signed [SAMPLE_W-1:0]  r_s1_data;
  logic                        r_s1_last;
  logic [W-1:0]                r_tri;
  logic                        r_s2_valid;
  logic signed [PW-1:0]        r_s2_prod;
  logic                        r_s2_last;
  logic                        r_m_valid;
  logic [OUT_W-1:0]            r_m_data;
  logic                        r_m_last;
  logic                        r_resync;

  // Handshake and stage-1 position. The whole pipe moves as one unit whenever
  // the output register is empty or being drained, so a stall freezes every
  // stage and nothing is dropped or duplicated.
  always_comb begin
    w_adv    = ~r_m_valid | m_ready_i;
    w_accept = s_valid_i & w_adv;
    w_pos    = s_first_i ? '0 : r_n;
    w_tri    = (w_pos >= C_HALF) ? (w_pos - C_HALF) : (C_HALF - w_pos);
  end

  // Datapath arithmetic. The sample is sign-extended and the coefficient
  // zero-extended to the full product width, so a signed multiply gives the
  // exact signed x unsigned product. Rounding adds half an LSB before the
  // arithmetic shift (round half up), then the result is clamped to OUT_W.
  always_comb begin
    w_mul_a = {{(PW-SAMPLE_W){r_s1_data[SAMPLE_W-1]}}, r_s1_data};
    w_mul_b = {{(PW-WW){1'b0}}, win_i};
    w_prod  = w_mul_a * w_mul_b;
    w_round = (r_s2_prod + C_RND) >>> WIN_FRAC;
    if (w_round > C_MAX) begin
      w_sat = C_MAX[OUT_W-1:0];
    end else if (w_round < C_MIN) begin
      w_sat = C_MIN[OUT_W-1:0];
    end else begin
      w_sat = w_round[OUT_W-1:0];
    end
  end

  // Position counter and resync pulse. The pulse only fires when the forced
  // restart actually moves the frame, a first flag at n = 0 is silent.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_n      <= '0;
      r_resync <= 1'b0;
    end else begin
      r_resync <= w_accept & s_first_i & (r_n != '0);
      if (w_accept) begin
        r_n <= (w_pos == C_LAST) ? '0 : (w_pos + W'(1));
      end
    end
  end

  // Three pipeline stages. tri_o is only rewritten by an accepted sample, so
  // it keeps its last value while stage 1 holds a bubble, which keeps the
  // external coefficient block quiet. Data registers load only behind a valid
  // stage so bubbles do not disturb the held output.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_last  <= 1'b0;
      r_tri      <= C_HALF;
      r_s2_valid <= 1'b0;
      r_s2_prod  <= '0;
      r_s2_last  <= 1'b0;
      r_m_valid  <= 1'b0;
      r_m_data   <= '0;
      r_m_last   <= 1'b0;
    end else if (w_adv) begin
      r_s1_valid <= s_valid_i;
      if (w_accept) begin
        r_s1_data <= s_data_i;
        r_s1_last <= (w_pos == C_LAST);
        r_tri     <= w_tri;
      end
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_prod <= w_prod;
        r_s2_last <= r_s1_last;
      end
      r_m_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_m_data <= w_sat;
        r_m_last <= r_s2_last;
      end
    end
  end

  assign s_ready_o = w_adv;
  assign tri_o     = r_tri;
  assign m_valid_o = r_m_valid;
  assign m_data_o  = r_m_data;
  assign m_last_o  = r_m_last;
  assign resync_o  = r_resync;

endmodule

// File: tb/tb_parzen_frame_windower.sv
// tb_parzen_frame_windower
//   Self-checking bench for parzen_frame_windower with N = 16. A golden Parzen
//   coefficient model drives win_i from tri_o unless a fixed coefficient is
//   selected for the rounding/saturation vectors. A negedge monitor predicts
//   position, tri_o, resync_o and every output sample/last flag.
module tb_parzen_frame_windower;

  logic               clk;
  logic               rst_i;
  logic               s_valid;
  logic               s_ready;
  logic signed [15:0] s_data;
  logic               s_first;
  logic [3:0]         tri_o;
  logic [25:0]        win_i;
  logic               m_valid;
  logic               m_ready;
  logic signed [17:0] m_data;
  logic               m_last;
  logic               resync;

  logic               winOverride;
  logic [25:0]        winOvr;

  int checks;
  int errors;
  int cyc;
  int lastAcceptCyc;
  int riseCyc;
  int outCount;
  int lastCount;
  int lastOutIdx;
  int resyncCount;
  int nModel;
  int triExp;
  bit resyncExp;
  bit prevValid;

  typedef struct {
    longint data;
    bit     last;
  } exp_t;

  exp_t expQ[$];

  typedef struct {
    logic signed [15:0] sample;
    logic [25:0]        win;
    longint             expOut;
  } vec_t;

  vec_t vecs[15];

  parzen_frame_windower #(
    .WINDOW_SIZE_POW2(4),
    .SAMPLE_W(16),
    .WIN_INT(10),
    .WIN_FRAC(16),
    .OUT_W(18)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .s_valid_i(s_valid),
    .s_ready_o(s_ready),
    .s_data_i (s_data),
    .s_first_i(s_first),
    .tri_o    (tri_o),
    .win_i    (win_i),
    .m_valid_o(m_valid),
    .m_ready_i(m_ready),
    .m_data_o (m_data),
    .m_last_o (m_last),
    .resync_o (resync)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Parzen window with half-width 8, u = t/8, in Q16:
  // t <= 4: 1 - 6u^2 + 6u^3, else 2(1-u)^3. Scaled by 512 then by 128.
  function automatic int parzenQ16(input int t);
    if (t <= 4) return (512 - 48*t*t + 6*t*t*t) * 128;
    return 2 * (8-t) * (8-t) * (8-t) * 128;
  endfunction

  function automatic longint modelOut(input longint s, input longint w);
    longint r;
    r = (s * w + 32768) >>> 16;
    if (r > 131071) return 131071;
    if (r < -131072) return -131072;
    return r;
  endfunction

  // Coefficient block returning win_i combinationally from tri_o.
  always_comb begin
    win_i = winOverride ? winOvr : 26'(parzenQ16(int'(tri_o)));
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drive one sample and hold it until the DUT accepts it; returns at posedge+1.
  task automatic applyStimulus(input logic signed [15:0] data, input logic first);
    int k;
    s_valid = 1'b1;
    s_data  = data;
    s_first = first;
    k = 0;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      k++;
      if (k >= 50) break;
    end
    checkOutput("accept_in_time", (k < 50) ? 1 : 0, 1);
    lastAcceptCyc = cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s_valid = 1'b0;
    s_first = 1'b0;
  endtask

  task automatic doReset();
    idle();
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (expQ.size() != 0 && k < 100) begin
      @(posedge clk);
      k++;
    end
    #1;
    checkOutput("drain_empty", expQ.size(), 0);
  endtask

  task automatic waitOutput(output longint got);
    int k;
    k = 0;
    got = 0;
    forever begin
      @(negedge clk);
      if (m_valid) break;
      k++;
      if (k >= 20) break;
    end
    checkOutput("output_in_time", (k < 20) ? 1 : 0, 1);
    got = m_data;
    @(posedge clk);
    #1;
  endtask

  // Negedge monitor step: compares tri_o, resync_o and output beats against
  // the model, then advances the model on an input handshake.
  task automatic monitorStep();
    int p;
    longint coef;
    if (rst_i) begin
      expQ.delete();
      nModel    = 0;
      triExp    = 8;
      resyncExp = 1'b0;
      prevValid = 1'b0;
    end else begin
      checkOutput("tri_o", tri_o, triExp);
      checkOutput("resync_o", resync, resyncExp);
      if (m_valid) begin
        if (!prevValid) riseCyc = cyc;
        if (expQ.size() == 0) begin
          checkOutput("spurious_valid", 1, 0);
        end else begin
          checkOutput("m_data", m_data, expQ[0].data);
          checkOutput("m_last", m_last, expQ[0].last);
          if (m_ready) begin
            void'(expQ.pop_front());
            outCount++;
            if (m_last) begin
              lastCount++;
              lastOutIdx = outCount - 1;
            end
          end
        end
      end
      prevValid = m_valid;
      if (resync) resyncCount++;
      resyncExp = 1'b0;
      if (s_valid && s_ready) begin
        p         = s_first ? 0 : nModel;
        resyncExp = s_first && (nModel != 0);
        triExp    = (p >= 8) ? (p - 8) : (8 - p);
        coef      = winOverride ? longint'(winOvr) : longint'(parzenQ16(triExp));
        expQ.push_back('{modelOut(s_data, coef), (p == 15)});
        nModel    = (p == 15) ? 0 : p + 1;
      end
    end
  endtask

  initial begin
    int base, baseLast, baseRes, firstAccept;
    longint got;

    checks = 0; errors = 0; cyc = 0; riseCyc = -1; lastAcceptCyc = 0;
    outCount = 0; lastCount = 0; lastOutIdx = 0; resyncCount = 0;
    nModel = 0; triExp = 8; resyncExp = 1'b0; prevValid = 1'b0;
    rst_i = 1'b1; s_valid = 1'b0; s_data = '0; s_first = 1'b0;
    m_ready = 1'b1; winOverride = 1'b0; winOvr = '0;

    vecs[0]  = '{16'sd1000,   26'h0010000, 1000};
    vecs[1]  = '{16'sd3,      26'h0008000, 2};
    vecs[2]  = '{-16'sd3,     26'h0008000, -1};
    vecs[3]  = '{-16'sd32768, 26'h0080000, -131072};
    vecs[4]  = '{16'sd32767,  26'h0080000, 131071};
    vecs[5]  = '{16'sd5,      26'h0004000, 1};
    vecs[6]  = '{-16'sd5,     26'h0004000, -1};
    vecs[7]  = '{16'sd2,      26'h0004000, 1};
    vecs[8]  = '{-16'sd2,     26'h0004000, 0};
    vecs[9]  = '{16'sd16384,  26'h0080000, 131071};
    vecs[10] = '{16'sd16383,  26'h0080000, 131064};
    vecs[11] = '{-16'sd16385, 26'h0080000, -131072};
    vecs[12] = '{-16'sd1,     26'h0010000, -1};
    vecs[13] = '{16'sd32767,  26'h3FFFFFF, 131071};
    vecs[14] = '{-16'sd32768, 26'h3FFFFFF, -131072};

    fork
      forever begin
        @(posedge clk);
        cyc++;
      end
      forever begin
        @(negedge clk);
        monitorStep();
      end
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    doReset();
    checkOutput("rst_m_valid", m_valid, 0);
    checkOutput("rst_m_data", m_data, 0);
    checkOutput("rst_m_last", m_last, 0);
    checkOutput("rst_resync", resync, 0);
    checkOutput("rst_tri", tri_o, 8);
    checkOutput("rst_s_ready", s_ready, 1);

    // Full frame back-to-back; first flag at n = 0 must stay silent
    $display("[TB] frame streaming");
    base = outCount; baseLast = lastCount;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(16'(2000 + 1000*i), (i == 0) ? 1'b1 : 1'b0);
      if (i == 0) begin
        firstAccept = lastAcceptCyc;
        checkOutput("silent_first", resync, 0);
      end
      checkOutput($sformatf("tri_seq%0d", i), tri_o, (i >= 8) ? (i - 8) : (8 - i));
    end
    idle();
    drain();
    checkOutput("latency", riseCyc - firstAccept, 3);
    checkOutput("frame_out_count", outCount - base, 16);
    checkOutput("frame_last_count", lastCount - baseLast, 1);
    checkOutput("frame_last_pos", lastOutIdx - base, 15);

    // Rounding and saturation vectors with a fixed coefficient
    $display("[TB] rounding and saturation vectors");
    doReset();
    winOverride = 1'b1;
    for (int i = 0; i < 15; i++) begin
      winOvr = vecs[i].win;
      applyStimulus(vecs[i].sample, 1'b0);
      idle();
      waitOutput(got);
      checkOutput($sformatf("vec%0d", i), got, vecs[i].expOut);
    end
    drain();
    winOverride = 1'b0;

    // Backpressure: m_ready low for 5 cycles mid-frame
    $display("[TB] backpressure");
    doReset();
    base = outCount;
    fork
      begin
        for (int i = 0; i < 16; i++) applyStimulus(16'(100*i - 700), 1'b0);
        idle();
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        m_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          checkOutput("bp_m_valid", m_valid, 1);
          checkOutput("bp_s_ready", s_ready, 0);
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
      end
    join
    drain();
    checkOutput("bp_out_count", outCount - base, 16);

    // Resync at n = 5
    $display("[TB] resync");
    doReset();
    base = outCount; baseLast = lastCount; baseRes = resyncCount;
    for (int i = 0; i < 5; i++) applyStimulus(16'(3000 + 10*i), 1'b0);
    applyStimulus(16'sd12345, 1'b1);
    checkOutput("resync_pulse", resync, 1);
    checkOutput("resync_tri", tri_o, 8);
    for (int i = 0; i < 15; i++) applyStimulus(16'(-4000 + 500*i), 1'b0);
    idle();
    drain();
    checkOutput("resync_count", resyncCount - baseRes, 1);
    checkOutput("resync_last_count", lastCount - baseLast, 1);
    checkOutput("resync_last_pos", lastOutIdx - base, 20);

    // Reset mid-frame at n = 9 with the pipe full
    $display("[TB] reset mid-frame");
    doReset();
    for (int i = 0; i < 9; i++) applyStimulus(16'(500 + i), 1'b0);
    idle();
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    checkOutput("midrst_m_valid", m_valid, 0);
    checkOutput("midrst_tri", tri_o, 8);
    applyStimulus(16'sd1234, 1'b0);
    checkOutput("midrst_first_tri", tri_o, 8);
    applyStimulus(16'sd1234, 1'b0);
    checkOutput("midrst_second_tri", tri_o, 7);
    idle();
    waitOutput(got);
    checkOutput("midrst_out0", got, 0);
    waitOutput(got);
    checkOutput("midrst_out1", got, 5);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
